// File: rtl/regfile_sb.sv
// Register file with write-back source select, same-edge write-to-read bypass
// and a per-register busy scoreboard for outstanding loads.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data_alu,
   input  logic [DATA_W-1:0] wr_data_mem,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   output logic              busy_any
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   logic [DATA_W-1:0]   regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_next_s;
   logic [DATA_W-1:0]   wr_data_s;
   logic                wr_ok_s;
   logic                claim_ok_s;
   logic [ADDR_W-1:0]   port_addr_s [2];
   logic [DATA_W-1:0]   port_data_s [2];
   logic                port_busy_s [2];

   assign port_addr_s[0] = rd_addr1;
   assign port_addr_s[1] = rd_addr2;

   // Write-back data select, register-0 filtering and next scoreboard state
   always_comb begin
      wr_data_s   = wr_sel ? wr_data_alu : wr_data_mem;
      wr_ok_s     = wr_en && !(ZERO_REG && (wr_addr == ADDR_ZERO));
      claim_ok_s  = claim_en && !(ZERO_REG && (claim_addr == ADDR_ZERO));
      busy_next_s = busy_r;
      if (wr_ok_s) begin
         busy_next_s[wr_addr] = 1'b0;
      end else begin
         busy_next_s = busy_next_s;
      end
      // Claim is applied after the clear so it wins on a shared address
      if (claim_ok_s) begin
         busy_next_s[claim_addr] = 1'b1;
      end else begin
         busy_next_s = busy_next_s;
      end
   end

   // Per-port read value: zero register, then bypass, then array contents
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         port_data_s[p] = regs_r[port_addr_s[p]];
         port_busy_s[p] = busy_r[port_addr_s[p]];
         if (ZERO_REG && (port_addr_s[p] == ADDR_ZERO)) begin
            port_data_s[p] = {DATA_W{1'b0}};
            port_busy_s[p] = 1'b0;
         end else if (BYPASS && wr_ok_s && (wr_addr == port_addr_s[p])) begin
            port_data_s[p] = wr_data_s;
            port_busy_s[p] = claim_ok_s && (claim_addr == port_addr_s[p]);
         end else begin
            port_data_s[p] = regs_r[port_addr_s[p]];
            port_busy_s[p] = busy_r[port_addr_s[p]];
         end
      end
   end

   // Register array write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         regs_r[wr_addr] <= wr_data_s;
      end
   end

   // Scoreboard and its registered summary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= {NUM_REGS{1'b0}};
         busy_any <= 1'b0;
      end else begin
         busy_r   <= busy_next_s;
         busy_any <= |busy_next_s;
      end
   end

   // Registered read ports, holding while rd_en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data1 <= {DATA_W{1'b0}};
         rd_data2 <= {DATA_W{1'b0}};
         rd_busy1 <= 1'b0;
         rd_busy2 <= 1'b0;
      end else if (rd_en) begin
         rd_data1 <= port_data_s[0];
         rd_data2 <= port_data_s[1];
         rd_busy1 <= port_busy_s[0];
         rd_busy2 <= port_busy_s[1];
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing and a non-bypassing instance
// driven in lockstep and compared every cycle against an array-based model.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        rd_en;
   logic [4:0]  rd_addr1, rd_addr2;
   logic        wr_en, wr_sel;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data_alu, wr_data_mem;
   logic        claim_en;
   logic [4:0]  claim_addr;

   logic [31:0] b_rd_data1, b_rd_data2, n_rd_data1, n_rd_data2;
   logic        b_rd_busy1, b_rd_busy2, n_rd_busy1, n_rd_busy2;
   logic        b_busy_any, n_busy_any;

   int tests = 0;
   int fails = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
      .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data_alu(wr_data_alu), .wr_data_mem(wr_data_mem),
      .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(b_busy_any));

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
      .rd_busy1(n_rd_busy1), .rd_busy2(n_rd_busy2),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data_alu(wr_data_alu), .wr_data_mem(wr_data_mem),
      .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(n_busy_any));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: architectural registers, busy set, and expected outputs
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   logic [31:0] e_b_d1 = 32'd0, e_b_d2 = 32'd0, e_n_d1 = 32'd0, e_n_d2 = 32'd0;
   bit          e_b_b1 = 1'b0, e_b_b2 = 1'b0, e_n_b1 = 1'b0, e_n_b2 = 1'b0;
   bit          e_any = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_read(input logic [4:0] a, input logic [31:0] wd,
                                      input bit byp, output logic [31:0] d, output bit b);
      if (a == 5'd0) begin
         d = 32'd0; b = 1'b0;
      end else if (byp && wr_en && wr_addr == a) begin
         d = wd; b = claim_en && claim_addr == a;
      end else begin
         d = m_regs[a]; b = m_busy[a];
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_busy[i] = 1'b0; end
         e_b_d1 = 32'd0; e_b_d2 = 32'd0; e_n_d1 = 32'd0; e_n_d2 = 32'd0;
         e_b_b1 = 1'b0; e_b_b2 = 1'b0; e_n_b1 = 1'b0; e_n_b2 = 1'b0; e_any = 1'b0;
      end else begin
         logic [31:0] wd;
         wd = wr_sel ? wr_data_alu : wr_data_mem;
         if (rd_en) begin
            model_read(rd_addr1, wd, 1'b1, e_b_d1, e_b_b1);
            model_read(rd_addr2, wd, 1'b1, e_b_d2, e_b_b2);
            model_read(rd_addr1, wd, 1'b0, e_n_d1, e_n_b1);
            model_read(rd_addr2, wd, 1'b0, e_n_d2, e_n_b2);
         end
         if (wr_en && wr_addr != 5'd0) begin
            m_regs[wr_addr] = wd;
            m_busy[wr_addr] = 1'b0;
         end
         if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
         e_any = 1'b0;
         for (int i = 0; i < 32; i++) e_any = e_any | m_busy[i];
      end
   end

   // Cycle-by-cycle comparison of both instances against the model
   always @(negedge clk) begin
      check("b_rd_data1", b_rd_data1, e_b_d1);
      check("b_rd_data2", b_rd_data2, e_b_d2);
      check("b_rd_busy1", {31'd0, b_rd_busy1}, {31'd0, e_b_b1});
      check("b_rd_busy2", {31'd0, b_rd_busy2}, {31'd0, e_b_b2});
      check("b_busy_any", {31'd0, b_busy_any}, {31'd0, e_any});
      check("n_rd_data1", n_rd_data1, e_n_d1);
      check("n_rd_data2", n_rd_data2, e_n_d2);
      check("n_rd_busy1", {31'd0, n_rd_busy1}, {31'd0, e_n_b1});
      check("n_rd_busy2", {31'd0, n_rd_busy2}, {31'd0, e_n_b2});
      check("n_busy_any", {31'd0, n_busy_any}, {31'd0, e_any});
   end

   task automatic cyc(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                      input logic we, input logic sel, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic ce, input logic [4:0] ca);
      rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
      wr_en = we; wr_sel = sel; wr_addr = wa; wr_data_alu = alu; wr_data_mem = mem;
      claim_en = ce; claim_addr = ca;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      rd_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
      wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 5'd0;
      wr_data_alu = 32'd0; wr_data_mem = 32'd0;
      claim_en = 1'b0; claim_addr = 5'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset then read
      cyc(1'b1, 5'd0, 5'd31, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("lit_reset_d1", b_rd_data1, 32'd0);
      check("lit_reset_d2", b_rd_data2, 32'd0);
      check("lit_reset_any", {31'd0, b_busy_any}, 32'd0);

      // Write from memory path, then from ALU path
      cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 32'h1111_1111, 32'h0000_F0F0, 1'b0, 5'd0);
      cyc(1'b1, 5'd0, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("lit_mem_wr", b_rd_data2, 32'h0000_F0F0);
      cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 32'h0000_FFFF, 32'h2222_2222, 1'b0, 5'd0);
      cyc(1'b1, 5'd2, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("lit_alu_wr", b_rd_data2, 32'h0000_FFFF);
      check("lit_same_port", b_rd_data1, 32'h0000_FFFF);

      // Zero register: write and claim are both dropped
      cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 5'd0);
      cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5'd0);
      check("lit_zero_d1", b_rd_data1, 32'd0);
      check("lit_zero_any", {31'd0, b_busy_any}, 32'd0);

      // Bypass versus no bypass
      cyc(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'd0, 1'b0, 5'd0);
      check("lit_bypass", b_rd_data1, 32'h1234_5678);
      check("lit_no_bypass", n_rd_data1, 32'd0);

      // Scoreboard: claim, clear racing a claim, plain clear
      cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7);
      cyc(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("lit_claim_busy", {31'd0, b_rd_busy1}, 32'd1);
      check("lit_claim_any", {31'd0, b_busy_any}, 32'd1);
      cyc(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'd0, 32'h0000_0077, 1'b1, 5'd7);
      check("lit_race_byp_busy", {31'd0, b_rd_busy2}, 32'd1);
      check("lit_race_byp_data", b_rd_data2, 32'h0000_0077);
      cyc(1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7);
      check("lit_race_busy", {31'd0, b_rd_busy1}, 32'd1);
      cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'd0, 32'h0000_0088, 1'b0, 5'd0);
      cyc(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("lit_clear_busy", {31'd0, b_rd_busy1}, 32'd0);
      check("lit_clear_any", {31'd0, b_busy_any}, 32'd0);

      // Hold with rd_en low while other traffic happens
      cyc(1'b0, 5'd2, 5'd5, 1'b1, 1'b1, 5'd7, 32'h0BAD_0BAD, 32'd0, 1'b1, 5'd9);
      check("lit_hold", b_rd_data1, 32'h0000_0088);

      // Fill 1..31, leave some claims outstanding, then reset between edges
      for (int i = 1; i < 32; i++) begin
         cyc(1'b1, 5'(i - 1), 5'(i), 1'b1, i[0], 5'(i), 32'hA5A5_A5A5, 32'hA5A5_A5A5,
             i[2], 5'(i));
      end
      cyc(1'b1, 5'd30, 5'd31, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd12);
      check("lit_fill", b_rd_data2, 32'hA5A5_A5A5);
      cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 32'd0, 32'h3333_3333, 1'b0, 5'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("lit_async_d1", b_rd_data1, 32'd0);
      check("lit_async_d2", b_rd_data2, 32'd0);
      check("lit_async_any", {31'd0, b_busy_any}, 32'd0);
      check("lit_async_nb_d2", n_rd_data2, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i += 2) begin
         cyc(1'b1, 5'(i), 5'(i + 1), 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
         check("lit_post_reset", b_rd_data1 | b_rd_data2 | n_rd_data1 | n_rd_data2, 32'd0);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
